// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Adds two WIDTH-bit operands LSB-first, one bit
//            per clock, using a single full-adder slice and a carry flip-flop.
//            A start/done handshake frames each operation.
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous active-low reset
//            start  - request, sampled only while idle
//            a, b   - operands, captured on an accepted start
//            cin    - carry-in, captured on an accepted start
//            sub    - (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b
//            busy   - high while running or signalling done
//            done   - one-cycle pulse, sum/cout valid
//            sum    - result, held until the next operation completes
//            cout   - final carry-out (with sub: 1 = no borrow)
// Options  : `define SERIAL_ADDER_SUB_EN adds the sub port (two's-complement
//            subtraction by loading ~b and forcing carry-in to 1).
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    // Holds only the WIDTH-1 most recent sum bits; the final bit is merged
    // in combinationally on the last edge straight into sum.
    logic [WIDTH-2:0]   r_res;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_carry_nxt;
    logic [WIDTH-1:0]   w_res_nxt;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b = a + ~b + 1; the carry-out then reads as "no borrow".
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    assign w_accept    = (r_state == c_IDLE) && start;
    assign w_last      = (r_cnt == c_CNT_LAST);
    assign w_s         = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_res_nxt   = {w_s, r_res};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_nxt = c_RUN;
            c_RUN:   if (w_last) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state == c_RUN) || (r_state == c_DONE);
        done = (r_state == c_DONE);
    end

    // Datapath: operand shifters, carry, bit counter, result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == c_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
            r_res   <= w_res_nxt[WIDTH-1:1];
            if (w_last) begin
                // Counter returns to zero so it never exceeds WIDTH-1.
                r_cnt <= '0;
                sum   <= w_res_nxt;
                cout  <= w_carry_nxt;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder; successor to the single-bit combinational half/full adder cells.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder slice and a carry flip-flop.
- Start/done handshake allows it to be driven from lab top-levels or a small controller FSM.
- Trades latency for area: one adder slice regardless of WIDTH.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result; held until the next accepted start completes.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry and counter cleared. This applies from any state, including mid-RUN. The partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - load shift regs A<=a, B<=b, carry<=cin, cnt<=0; go to RUN.
  - busy=1 from after E0.
- RUN, each edge:
  - s = A[0]^B[0]^carry.
  - carry <= (A[0]&B[0]) | (carry&(A[0]^B[0])).
  - internal result reg shifts right with s inserted at MSB.
  - A and B shift right (zero fill); cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge (the WIDTH-th bit processed), go to DONE. The same edge copies the completed result into sum and the final carry into cout.
- DONE: done=1 for exactly one cycle; next edge goes to IDLE. On that edge busy and done both drop to 0.
- Latency: start accepted at E0 -> done high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 clocks from the start edge. Throughput: one add per WIDTH+2 clocks.
- start in RUN or DONE is ignored. Operands are not re-sampled. A start held high continuously is accepted again on the first IDLE cycle.
- sum/cout change only at the RUN->DONE edge or at reset. They are stable through IDLE and through the RUN of the next operation.
- a, b, cin may change freely after the start edge; the result depends only on the values captured at acceptance.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width: $clog2(WIDTH); it never exceeds WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - adds input port sub (1 bit), sampled with start.
  - sub=1: B loads ~b, carry loads 1 (cin ignored), result sum=a-b mod 2^WIDTH. cout=1 means no borrow (a>=b unsigned); cout=0 means borrow.
  - sub=0: identical to plain add.
- Undefined: no sub port; add only; logic and timing exactly as in Behaviour.

Test Plan (WIDTH=8):
- Add: start with a=8'h5A, b=8'h25, cin=0 -> done pulse exactly 9 clocks after the start edge, sum=8'h7F, cout=0; busy high for 9 cycles.
- Wrap with carry: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0. Previous sum must be held until the second done.
- Ignore start while busy: start a=8'h10, b=8'h20; pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 -> sum=8'h30, a single done pulse, no second operation. Held start -> next op starts the cycle after done falls.
- Reset mid-run: rst_n low at RUN cycle 4 for one edge -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse follows. A fresh start afterwards yields a correct result.
- Operand change after accept: a/b toggled randomly during RUN -> result equals the values captured at the start edge.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, cout=1.
  - a=8'h00, b=8'h01 -> sum=8'hFF, cout=0.
  - sub=1 with cin=0 and cin=1 gives identical results.
